apb_master_if: RTL and testbench
================================

# apb_master_if

Command-to-APB master bridge that sits directly upstream of the APB slave interface on the same bus. It accepts one read or write command at a time from a local host over a valid/ready handshake, runs the APB SETUP and ACCESS phases, and waits for PREADY with a bounded timeout. It then returns read data and error status on a held response channel. One transfer is outstanding at a time.

## Interface
Parameters:
- APB_DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- APB_ADDR_WIDTH, 32, address bus width.
- TIMEOUT_CYCLE, 16, maximum ACCESS-phase cycles before abort; must be ≥1.
- STRB_WIDTH (local), APB_DATA_WIDTH/8.

Ports:
- apb_clk_in  in  1  clock; all logic on rising edge.
- apb_rstn_in  in  1  reset, asynchronous, active-low.
- cmd_valid_in  in  1  host command valid.
- cmd_ready_out  out  1  command accepted when high with cmd_valid_in.
- cmd_addr_in  in  APB_ADDR_WIDTH  command address.
- cmd_write_in  in  1  1 = write, 0 = read.
- cmd_wdata_in  in  APB_DATA_WIDTH  write data.
- cmd_strb_in  in  STRB_WIDTH  write byte strobes.
- cmd_prot_in  in  3  protection attribute.
- rsp_valid_out  out  1  response valid; held until accepted.
- rsp_ready_in  in  1  host accepts response.
- rsp_rdata_out  out  APB_DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_error_out  out  1  PSLVERR seen, or timeout.
- rsp_timeout_out  out  1  transfer aborted by timeout.
- apb_addr_out  out  APB_ADDR_WIDTH  PADDR.
- apb_psel_out  out  1  PSEL.
- apb_penable_out  out  1  PENABLE.
- apb_write_out  out  1  PWRITE.
- apb_wdata_out  out  APB_DATA_WIDTH  PWDATA.
- apb_strb_out  out  STRB_WIDTH  PSTRB.
- apb_prot_out  out  3  PPROT.
- apb_rdata_in  in  APB_DATA_WIDTH  PRDATA.
- apb_ready_in  in  1  PREADY.
- apb_slverr_in  in  1  PSLVERR.

## Operation
- All outputs are registered.
- Reset is asynchronous: on assertion, every output goes to 0 immediately, the FSM goes to IDLE, and the timeout counter clears. An in-flight transfer is dropped with no response.
- **IDLE:** cmd_ready_out=1. On cmd_valid_in & cmd_ready_out:
  - latch addr, write, wdata, prot and strb onto the APB outputs;
  - force strb to 0 when write=0;
  - force wdata to 0 for reads;
  - set psel=1, penable=0, cmd_ready_out=0;
  - go to SETUP.
- **SETUP:** exactly one cycle. Set penable=1, clear the counter, go to ACCESS.
- **ACCESS:** addr, write, wdata, strb and prot stay stable; psel=penable=1.
  - apb_ready_in=1 at the edge completes the transfer:
    - capture rsp_rdata_out = write ? 0 : apb_rdata_in;
    - rsp_error_out = apb_slverr_in, rsp_timeout_out=0;
    - psel=penable=0, rsp_valid_out=1;
    - go to RESP.
  - apb_ready_in=0 with counter == TIMEOUT_CYCLE-1 aborts:
    - psel=penable=0, rsp_rdata_out=0;
    - rsp_error_out=1, rsp_timeout_out=1;
    - rsp_valid_out=1, go to RESP.
  - Otherwise the counter increments.
  - If PREADY and the timeout fall on the same cycle, PREADY wins: the transfer completes normally.
- **RESP:** response fields are held stable while rsp_valid_out=1. On rsp_ready_in=1:
  - rsp_valid_out=0, cmd_ready_out=1, return to IDLE;
  - APB address, data, strb and prot outputs keep their last values, with psel=0.
- Counter width is $clog2(TIMEOUT_CYCLE+1) and never wraps.
- Commands presented while cmd_ready_out=0 are ignored and not queued.

## Timing
- Command accepted at edge N. SETUP runs in cycle N+1 (psel=1, penable=0). ACCESS starts in cycle N+2.
- Zero-wait slave (PREADY=1 in N+2): rsp_valid_out=1 in cycle N+3, and the earliest next acceptance is one cycle after the response handshake.
- Each PREADY-low ACCESS cycle adds one cycle. ACCESS lasts at most TIMEOUT_CYCLE cycles.
- apb_penable_out is never high without apb_psel_out, and is never high in the first cycle of psel.
- Minimum issue interval with rsp_ready_in tied high: 4 cycles.

## Test plan
- **Reset values:** assert reset during ACCESS → all outputs 0 in the same cycle; after release cmd_ready_out=1 and psel=0.
- **Zero-wait write:** write addr 0x10, data 0xDEADBEEF, strb 0xF, slave PREADY=1 → psel/penable sequence 10,11; rsp_valid one cycle later, rsp_error=0, rsp_rdata=0.
- **Read with 3 wait states:** slave returns 0x12345678 with PSLVERR=1 → ACCESS lasts 4 cycles, strb=0, rsp_rdata=0x12345678, rsp_error=1, rsp_timeout=0.
- **Timeout:** TIMEOUT_CYCLE=16, PREADY held 0 → psel drops after 16 ACCESS cycles; rsp_error=1, rsp_timeout=1, rsp_rdata=0.
- **PREADY on the last allowed cycle** (16th) → normal completion, rsp_timeout=0.
- **Response backpressure:** rsp_ready_in low for 5 cycles → response fields stable and cmd_ready_out=0 throughout; new commands are ignored until the handshake.

Source files
------------

// File: rtl/apb_master_if.sv
// Command-to-APB master bridge: one host command at a time is run through the
// APB SETUP/ACCESS phases with a bounded PREADY wait, and answered on a held response channel.
module apb_master_if #(
    parameter int  APB_DATA_WIDTH = 32,
    parameter int  APB_ADDR_WIDTH = 32,
    parameter int  TIMEOUT_CYCLE  = 16,
    localparam int STRB_WIDTH     = APB_DATA_WIDTH / 8
) (
    input  logic                      apb_clk_in,
    input  logic                      apb_rstn_in,
    input  logic                      cmd_valid_in,
    output logic                      cmd_ready_out,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_in,
    input  logic                      cmd_write_in,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_in,
    input  logic [STRB_WIDTH-1:0]     cmd_strb_in,
    input  logic [2:0]                cmd_prot_in,
    output logic                      rsp_valid_out,
    input  logic                      rsp_ready_in,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_out,
    output logic                      rsp_error_out,
    output logic                      rsp_timeout_out,
    output logic [APB_ADDR_WIDTH-1:0] apb_addr_out,
    output logic                      apb_psel_out,
    output logic                      apb_penable_out,
    output logic                      apb_write_out,
    output logic [APB_DATA_WIDTH-1:0] apb_wdata_out,
    output logic [STRB_WIDTH-1:0]     apb_strb_out,
    output logic [2:0]                apb_prot_out,
    input  logic [APB_DATA_WIDTH-1:0] apb_rdata_in,
    input  logic                      apb_ready_in,
    input  logic                      apb_slverr_in
);

    localparam int                   CNT_WIDTH = $clog2(TIMEOUT_CYCLE + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

    state_t                    r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]      r_cnt, w_cnt_nxt;

    logic                      w_cmd_ready_nxt, w_rsp_valid_nxt, w_rsp_error_nxt, w_rsp_timeout_nxt;
    logic [APB_DATA_WIDTH-1:0] w_rsp_rdata_nxt, w_wdata_nxt;
    logic [APB_ADDR_WIDTH-1:0] w_addr_nxt;
    logic                      w_psel_nxt, w_penable_nxt, w_write_nxt;
    logic [STRB_WIDTH-1:0]     w_strb_nxt;
    logic [2:0]                w_prot_nxt;

    always_comb begin
        // NOTE: every next value defaults to its current value first, so no path can infer a latch.
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_cmd_ready_nxt   = cmd_ready_out;
        w_rsp_valid_nxt   = rsp_valid_out;
        w_rsp_rdata_nxt   = rsp_rdata_out;
        w_rsp_error_nxt   = rsp_error_out;
        w_rsp_timeout_nxt = rsp_timeout_out;
        w_addr_nxt        = apb_addr_out;
        w_psel_nxt        = apb_psel_out;
        w_penable_nxt     = apb_penable_out;
        w_write_nxt       = apb_write_out;
        w_wdata_nxt       = apb_wdata_out;
        w_strb_nxt        = apb_strb_out;
        w_prot_nxt        = apb_prot_out;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid_in && cmd_ready_out) begin
                    // Reads never drive write data or strobes onto the bus.
                    w_addr_nxt      = cmd_addr_in;
                    w_write_nxt     = cmd_write_in;
                    w_wdata_nxt     = cmd_write_in ? cmd_wdata_in : '0;
                    w_strb_nxt      = cmd_write_in ? cmd_strb_in : '0;
                    w_prot_nxt      = cmd_prot_in;
                    w_psel_nxt      = 1'b1;
                    w_penable_nxt   = 1'b0;
                    w_cmd_ready_nxt = 1'b0;
                    w_state_nxt     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY is tested before the timeout so a late ready still completes normally.
                if (apb_ready_in) begin
                    w_rsp_rdata_nxt   = apb_write_out ? '0 : apb_rdata_in;
                    w_rsp_error_nxt   = apb_slverr_in;
                    w_rsp_timeout_nxt = 1'b0;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_error_nxt   = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_in) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            cmd_ready_out   <= 1'b0;
            rsp_valid_out   <= 1'b0;
            rsp_rdata_out   <= '0;
            rsp_error_out   <= 1'b0;
            rsp_timeout_out <= 1'b0;
            apb_addr_out    <= '0;
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            apb_write_out   <= 1'b0;
            apb_wdata_out   <= '0;
            apb_strb_out    <= '0;
            apb_prot_out    <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            cmd_ready_out   <= w_cmd_ready_nxt;
            rsp_valid_out   <= w_rsp_valid_nxt;
            rsp_rdata_out   <= w_rsp_rdata_nxt;
            rsp_error_out   <= w_rsp_error_nxt;
            rsp_timeout_out <= w_rsp_timeout_nxt;
            apb_addr_out    <= w_addr_nxt;
            apb_psel_out    <= w_psel_nxt;
            apb_penable_out <= w_penable_nxt;
            apb_write_out   <= w_write_nxt;
            apb_wdata_out   <= w_wdata_nxt;
            apb_strb_out    <= w_strb_nxt;
            apb_prot_out    <= w_prot_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_if.sv
// Bench for apb_master_if: a transaction-level model predicts the bus and response
// channel for every cycle, and a negedge compare process checks the DUT against it.
`timescale 1ns/1ps
module tb_apb_master_if;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 16;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid_in = 1'b0, cmd_ready_out;
    logic [AW-1:0] cmd_addr_in = '0;
    logic          cmd_write_in = 1'b0;
    logic [DW-1:0] cmd_wdata_in = '0;
    logic [SW-1:0] cmd_strb_in = '0;
    logic [2:0]    cmd_prot_in = '0;
    logic          rsp_valid_out, rsp_ready_in = 1'b0;
    logic [DW-1:0] rsp_rdata_out;
    logic          rsp_error_out, rsp_timeout_out;
    logic [AW-1:0] apb_addr_out;
    logic          apb_psel_out, apb_penable_out, apb_write_out;
    logic [DW-1:0] apb_wdata_out;
    logic [SW-1:0] apb_strb_out;
    logic [2:0]    apb_prot_out;
    logic [DW-1:0] apb_rdata_in = '0;
    logic          apb_ready_in = 1'b0, apb_slverr_in = 1'b0;

    always #5 clk = ~clk;

    apb_master_if #(.APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLE(T)) dut (
        .apb_clk_in(clk), .apb_rstn_in(rstn),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_addr_in(cmd_addr_in), .cmd_write_in(cmd_write_in),
        .cmd_wdata_in(cmd_wdata_in), .cmd_strb_in(cmd_strb_in), .cmd_prot_in(cmd_prot_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .rsp_rdata_out(rsp_rdata_out), .rsp_error_out(rsp_error_out),
        .rsp_timeout_out(rsp_timeout_out),
        .apb_addr_out(apb_addr_out), .apb_psel_out(apb_psel_out),
        .apb_penable_out(apb_penable_out), .apb_write_out(apb_write_out),
        .apb_wdata_out(apb_wdata_out), .apb_strb_out(apb_strb_out),
        .apb_prot_out(apb_prot_out), .apb_rdata_in(apb_rdata_in),
        .apb_ready_in(apb_ready_in), .apb_slverr_in(apb_slverr_in)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected DUT outputs for the current cycle.
    typedef struct {
        logic          cmd_ready, psel, penable, write, rsp_valid, rsp_error, rsp_timeout;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata, rsp_rdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        bit            wr;
        logic [DW-1:0] wd;
        logic [SW-1:0] sb;
        logic [2:0]    pr;
        int            waits;   // PREADY-low ACCESS cycles before the slave answers
        logic [DW-1:0] rd;
        bit            se;
        int            bp;      // cycles rsp_ready_in stays low
    } txn_t;

    exp_t          e;
    bit            exp_en = 1'b0;
    logic [AW-1:0] m_addr;
    logic          m_write;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;
    logic [2:0]    m_prot;

    // Observations used by the hand-computed literal checks.
    int            acc_cnt = 0, rsp_cnt = 0;
    logic [DW-1:0] cap_rdata;
    logic          cap_err, cap_to;

    always @(negedge clk) begin
        if (exp_en) begin
            check("cmd_ready", cmd_ready_out, e.cmd_ready);
            check("psel", apb_psel_out, e.psel);
            check("penable", apb_penable_out, e.penable);
            check("paddr", apb_addr_out, e.addr);
            check("pwrite", apb_write_out, e.write);
            check("pwdata", apb_wdata_out, e.wdata);
            check("pstrb", apb_strb_out, e.strb);
            check("pprot", apb_prot_out, e.prot);
            check("rsp_valid", rsp_valid_out, e.rsp_valid);
            if (e.rsp_valid) begin
                check("rsp_rdata", rsp_rdata_out, e.rsp_rdata);
                check("rsp_error", rsp_error_out, e.rsp_error);
                check("rsp_timeout", rsp_timeout_out, e.rsp_timeout);
            end
        end
    end

    always @(negedge clk) begin
        if (apb_psel_out && apb_penable_out) acc_cnt <= acc_cnt + 1;
        if (rsp_valid_out) begin
            rsp_cnt   <= rsp_cnt + 1;
            cap_rdata <= rsp_rdata_out;
            cap_err   <= rsp_error_out;
            cap_to    <= rsp_timeout_out;
        end
    end

    function automatic void set_bus(input bit ps, input bit pe);
        e.psel  = ps;     e.penable = pe;
        e.addr  = m_addr; e.write   = m_write; e.wdata = m_wdata;
        e.strb  = m_strb; e.prot    = m_prot;
    endfunction

    function automatic void model_reset();
        m_addr = '0; m_write = 1'b0; m_wdata = '0; m_strb = '0; m_prot = '0;
        e.cmd_ready = 1'b1; e.rsp_valid = 1'b0;
        e.rsp_rdata = '0; e.rsp_error = 1'b0; e.rsp_timeout = 1'b0;
        set_bus(1'b0, 1'b0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Commands shown while the bridge is busy must be ignored.
    task automatic drive_junk();
        cmd_valid_in  = 1'b1;
        cmd_addr_in   = $urandom();
        cmd_write_in  = 1'($urandom_range(0, 1));
        cmd_wdata_in  = $urandom();
        cmd_strb_in   = SW'($urandom());
        cmd_prot_in   = 3'($urandom());
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            cmd_valid_in = 1'b0;
            rsp_ready_in = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    // Entered in an idle cycle with cmd_ready high; leaves in the idle cycle after the handshake.
    task automatic run_txn(input txn_t t);
        bit timed_out;
        bit done;
        int k;
        acc_cnt = 0;
        rsp_cnt = 0;
        cmd_valid_in = 1'b1; cmd_addr_in = t.addr; cmd_write_in = t.wr;
        cmd_wdata_in = t.wd; cmd_strb_in = t.sb; cmd_prot_in = t.pr;
        rsp_ready_in = 1'b0;
        step();
        // SETUP: one cycle, psel without penable.
        m_addr = t.addr; m_write = t.wr; m_prot = t.pr;
        m_wdata = t.wr ? t.wd : '0;
        m_strb  = t.wr ? t.sb : '0;
        e.cmd_ready = 1'b0; e.rsp_valid = 1'b0;
        set_bus(1'b1, 1'b0);
        drive_junk();
        rsp_ready_in  = 1'($urandom_range(0, 1));
        apb_ready_in  = 1'($urandom_range(0, 1));
        apb_rdata_in  = $urandom();
        apb_slverr_in = 1'($urandom_range(0, 1));
        step();
        // ACCESS: lasts until the slave answers or T cycles have elapsed.
        set_bus(1'b1, 1'b1);
        k = 0;
        forever begin
            if (k == t.waits) begin
                apb_ready_in = 1'b1; apb_rdata_in = t.rd; apb_slverr_in = t.se;
            end else begin
                apb_ready_in = 1'b0; apb_rdata_in = $urandom();
                apb_slverr_in = 1'($urandom_range(0, 1));
            end
            drive_junk();
            rsp_ready_in = 1'($urandom_range(0, 1));
            done = (k == t.waits) || (k == T - 1);
            step();
            if (done) break;
            k++;
        end
        // RESP: held until the host takes it.
        timed_out     = (t.waits >= T);
        e.rsp_valid   = 1'b1;
        e.rsp_rdata   = (timed_out || t.wr) ? '0 : t.rd;
        e.rsp_error   = timed_out ? 1'b1 : t.se;
        e.rsp_timeout = timed_out;
        set_bus(1'b0, 1'b0);
        apb_ready_in  = 1'($urandom_range(0, 1));
        apb_rdata_in  = $urandom();
        for (int b = 0; b <= t.bp; b++) begin
            rsp_ready_in = (b == t.bp);
            drive_junk();
            step();
        end
        e.rsp_valid  = 1'b0;
        e.cmd_ready  = 1'b1;
        cmd_valid_in = 1'b0;
        rsp_ready_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready_out, 1'b0);
        check("reset_psel", apb_psel_out, 1'b0);
        check("reset_rsp_valid", rsp_valid_out, 1'b0);
        @(posedge clk);
        #2 rstn = 1'b1;
        step();
        check("post_reset_cmd_ready", cmd_ready_out, 1'b1);
        check("post_reset_psel", apb_psel_out, 1'b0);
        model_reset();
        exp_en = 1'b1;

        // Zero-wait write.
        t = '{addr: 32'h10, wr: 1'b1, wd: 32'hDEADBEEF, sb: 4'hF, pr: 3'd2,
              waits: 0, rd: 32'hAAAA5555, se: 1'b0, bp: 0};
        run_txn(t);
        check("zw_access_cycles", acc_cnt, 1);
        check("zw_rsp_rdata", cap_rdata, 32'h0);
        check("zw_rsp_error", cap_err, 1'b0);
        idle_cycles(1);

        // Read with 3 wait states and a slave error.
        t = '{addr: 32'h24, wr: 1'b0, wd: 32'hFFFF0000, sb: 4'hF, pr: 3'd5,
              waits: 3, rd: 32'h12345678, se: 1'b1, bp: 0};
        run_txn(t);
        check("rd3_access_cycles", acc_cnt, 4);
        check("rd3_rsp_rdata", cap_rdata, 32'h12345678);
        check("rd3_rsp_error", cap_err, 1'b1);
        check("rd3_rsp_timeout", cap_to, 1'b0);
        check("rd3_pstrb", apb_strb_out, 4'h0);

        // Slave never answers.
        t = '{addr: 32'h40, wr: 1'b0, wd: 32'h0, sb: 4'h3, pr: 3'd0,
              waits: T + 5, rd: 32'h0BADF00D, se: 1'b0, bp: 0};
        run_txn(t);
        check("to_access_cycles", acc_cnt, 16);
        check("to_rsp_rdata", cap_rdata, 32'h0);
        check("to_rsp_error", cap_err, 1'b1);
        check("to_rsp_timeout", cap_to, 1'b1);

        // PREADY on the last allowed ACCESS cycle.
        t = '{addr: 32'h44, wr: 1'b0, wd: 32'h0, sb: 4'h0, pr: 3'd7,
              waits: T - 1, rd: 32'hCAFEF00D, se: 1'b0, bp: 0};
        run_txn(t);
        check("last_access_cycles", acc_cnt, 16);
        check("last_rsp_rdata", cap_rdata, 32'hCAFEF00D);
        check("last_rsp_timeout", cap_to, 1'b0);
        check("last_rsp_error", cap_err, 1'b0);

        // Response backpressure for 5 cycles.
        t = '{addr: 32'h80, wr: 1'b1, wd: 32'h01020304, sb: 4'h5, pr: 3'd1,
              waits: 1, rd: 32'h0, se: 1'b0, bp: 5};
        run_txn(t);
        check("bp_rsp_valid_cycles", rsp_cnt, 6);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            t.addr  = $urandom();
            t.wr    = 1'($urandom_range(0, 1));
            t.wd    = $urandom();
            t.sb    = SW'($urandom());
            t.pr    = 3'($urandom());
            t.waits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T - 2, T + 3))
                                                  : int'($urandom_range(0, 4));
            t.rd    = $urandom();
            t.se    = 1'($urandom_range(0, 1));
            t.bp    = $urandom_range(0, 3);
            run_txn(t);
            idle_cycles($urandom_range(0, 2));
        end

        // Reset asserted in the middle of ACCESS.
        exp_en = 1'b0;
        cmd_valid_in = 1'b1; cmd_addr_in = 32'h1234; cmd_write_in = 1'b1;
        cmd_wdata_in = 32'h55AA55AA; cmd_strb_in = 4'hF; cmd_prot_in = 3'd3;
        step();
        cmd_valid_in = 1'b0;
        apb_ready_in = 1'b0;
        step();
        check("pre_reset_access", {apb_psel_out, apb_penable_out}, 2'b11);
        #1 rstn = 1'b0;
        #1;
        check("arst_cmd_ready", cmd_ready_out, 1'b0);
        check("arst_psel", apb_psel_out, 1'b0);
        check("arst_penable", apb_penable_out, 1'b0);
        check("arst_paddr", apb_addr_out, 32'h0);
        check("arst_pwrite", apb_write_out, 1'b0);
        check("arst_pwdata", apb_wdata_out, 32'h0);
        check("arst_pstrb", apb_strb_out, 4'h0);
        check("arst_pprot", apb_prot_out, 3'h0);
        check("arst_rsp_valid", rsp_valid_out, 1'b0);
        check("arst_rsp_rdata", rsp_rdata_out, 32'h0);
        check("arst_rsp_error", rsp_error_out, 1'b0);
        check("arst_rsp_timeout", rsp_timeout_out, 1'b0);
        @(posedge clk);
        #2 rstn = 1'b1;
        step();
        check("rel_cmd_ready", cmd_ready_out, 1'b1);
        check("rel_psel", apb_psel_out, 1'b0);
        check("rel_rsp_valid", rsp_valid_out, 1'b0);
        model_reset();
        exp_en = 1'b1;

        t = '{addr: 32'hC0, wr: 1'b0, wd: 32'h0, sb: 4'hF, pr: 3'd4,
              waits: 2, rd: 32'h87654321, se: 1'b0, bp: 1};
        run_txn(t);
        check("after_reset_rdata", cap_rdata, 32'h87654321);
        idle_cycles(2);
        exp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
